// File: rtl/fifo_unpacker.sv
// Drains InWidth-bit words from fifo_generic and emits them as OutWidth-bit beats, LSB first.
// A 2-entry prefetch queue covers the FIFO's 1-cycle read latency so beats stream without bubbles.
module fifo_unpacker #(
  parameter int InWidth  = 32,
  parameter int OutWidth = 8
) (
  input  logic                clk,
  input  logic                i_rst_n,
  output logic                o_fifo_read,
  input  logic [InWidth-1:0]  i_fifo_read_data,
  input  logic                i_fifo_empty,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [OutWidth-1:0] o_data,
  output logic                o_last,
  output logic                o_busy
);
  localparam int Ratio = InWidth / OutWidth;
  localparam int BW    = (Ratio > 1) ? $clog2(Ratio) : 1;

  generate
    if (InWidth % OutWidth != 0) begin : g_bad_ratio
      $error("fifo_unpacker: InWidth must be a multiple of OutWidth");
    end
  endgenerate

  logic [1:0]         r_occ;
  logic               r_inflight;
  logic [BW-1:0]      r_beat;
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [InWidth-1:0] r_q [2];

  logic               w_last_beat;
  logic               w_fire;
  logic               w_pop;
  logic [2:0]         w_occ_next;
  logic [InWidth-1:0] w_head;

  assign w_last_beat = (r_beat == BW'(Ratio - 1));
  assign o_valid     = (r_occ != 2'd0);
  assign w_fire      = o_valid && i_ready;
  assign w_pop       = w_fire && w_last_beat;
  assign w_occ_next  = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  // Only issue when the word will have a slot on arrival; reset gates the strobe directly.
  assign o_fifo_read = i_rst_n && !i_fifo_empty && (w_occ_next < 3'd2);
  assign o_last      = o_valid && w_last_beat;
  assign o_busy      = o_valid || r_inflight;
  assign w_head      = r_q[r_rd_ptr];

  generate
    if (Ratio == 1) begin : g_pass
      assign o_data = w_head;
    end else begin : g_slice
      logic [Ratio-1:0][OutWidth-1:0] w_slices;
      assign w_slices = w_head;
      assign o_data   = w_slices[r_beat];
    end
  endgenerate

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_beat     <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_inflight <= o_fifo_read;
      r_occ      <= w_occ_next[1:0];
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
      if (w_fire)     r_beat   <= w_last_beat ? '0 : r_beat + 1'b1;
    end
  end

  // Queue payload needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (r_inflight) r_q[r_wr_ptr] <= i_fifo_read_data;
  end
endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker: behavioural FIFOs feed a 32->8 and a 32->32 instance,
// accepted FIFO writes push expected beats into per-instance scoreboards.
module tb_fifo_unpacker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst1_n;
  logic rd0, emp0, vld0, rdy0, last0, busy0, we0;
  logic [31:0] rdd0, wd0;
  logic [7:0]  dat0;
  logic rd1, emp1, vld1, rdy1, last1, busy1, we1;
  logic [31:0] rdd1, wd1, dat1;

  typedef struct packed { logic [31:0] d; logic l; } exp_t;
  exp_t sb0[$], sb1[$];
  exp_t t0, t1, e0, e1;

  int n_tests = 0, n_fail = 0;
  int cyc_n = 0, beats0 = 0, beats1 = 0, t_first0 = 0, t_last0 = 0, t_first1 = 0, t_last1 = 0;
  int rdcnt0 = 0, rd_at_pop = -1, stalls0 = 0;
  bit pop_seen = 1'b0, hold_v0 = 1'b0;
  logic [9:0] hold0;

  fifo_unpacker #(.InWidth(32), .OutWidth(8)) u_dut0 (
    .clk(clk), .i_rst_n(rst_n), .o_fifo_read(rd0), .i_fifo_read_data(rdd0),
    .i_fifo_empty(emp0), .o_valid(vld0), .i_ready(rdy0), .o_data(dat0),
    .o_last(last0), .o_busy(busy0));

  fifo_unpacker #(.InWidth(32), .OutWidth(32)) u_dut1 (
    .clk(clk), .i_rst_n(rst1_n), .o_fifo_read(rd1), .i_fifo_read_data(rdd1),
    .i_fifo_empty(emp1), .o_valid(vld1), .i_ready(rdy1), .o_data(dat1),
    .o_last(last1), .o_busy(busy1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Depth-8 FIFOs with 1-cycle read latency; writes to a full FIFO are dropped.
  logic [31:0] m0 [8], m1 [8];
  int c0, wp0, rp0, c1, wp1, rp1;
  assign emp0 = (c0 == 0);
  assign emp1 = (c1 == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0 <= 0; wp0 <= 0; rp0 <= 0; sb0.delete();
    end else begin
      if (rd0) begin rdd0 <= m0[rp0]; rp0 <= (rp0 + 1) % 8; end
      if (we0 && c0 < 8) begin
        m0[wp0] <= wd0; wp0 <= (wp0 + 1) % 8;
        for (int k = 0; k < 4; k++) begin
          t0.d = (wd0 >> (8 * k)) & 32'hFF; t0.l = (k == 3); sb0.push_back(t0);
        end
      end
      c0 <= c0 + ((we0 && c0 < 8) ? 1 : 0) - (rd0 ? 1 : 0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1 <= 0; wp1 <= 0; rp1 <= 0; sb1.delete();
    end else begin
      if (rd1) begin rdd1 <= m1[rp1]; rp1 <= (rp1 + 1) % 8; end
      if (we1 && c1 < 8) begin
        m1[wp1] <= wd1; wp1 <= (wp1 + 1) % 8;
        t1.d = wd1; t1.l = 1'b1; sb1.push_back(t1);
      end
      c1 <= c1 + ((we1 && c1 < 8) ? 1 : 0) - (rd1 ? 1 : 0);
    end
  end

  // Output monitor: a beat is accepted at the posedge following a negedge with valid&&ready.
  always @(negedge clk) begin
    cyc_n++;
    if (rst_n) begin
      chk("no_read_when_empty0", {63'b0, rd0 && emp0}, 64'd0);
      if (hold_v0) begin
        chk("stall_stable0", {54'b0, vld0, dat0, last0}, {54'b0, hold0});
        stalls0++;
      end
      hold_v0 = vld0 && !rdy0;
      hold0   = {vld0, dat0, last0};
      if (vld0 && rdy0) begin
        if (last0 && !pop_seen) begin pop_seen = 1'b1; rd_at_pop = rdcnt0; end
        if (sb0.size() == 0) chk("beat_unexpected0", 64'd1, 64'd0);
        else begin
          e0 = sb0.pop_front();
          chk("beat_data0", {56'b0, dat0}, {32'b0, e0.d});
          chk("beat_last0", {63'b0, last0}, {63'b0, e0.l});
        end
        if (beats0 == 0) t_first0 = cyc_n;
        t_last0 = cyc_n;
        beats0++;
      end
      if (rd0) rdcnt0++;
    end else hold_v0 = 1'b0;
    if (rst_n && rst1_n) begin
      chk("no_read_when_empty1", {63'b0, rd1 && emp1}, 64'd0);
      if (vld1 && rdy1) begin
        if (sb1.size() == 0) chk("beat_unexpected1", 64'd1, 64'd0);
        else begin
          e1 = sb1.pop_front();
          chk("beat_data1", {32'b0, dat1}, {32'b0, e1.d});
          chk("beat_last1", {63'b0, last1}, {63'b0, e1.l});
        end
        if (beats1 == 0) t_first1 = cyc_n;
        t_last1 = cyc_n;
        beats1++;
      end
    end
  end

  task automatic wr0(input logic [31:0] d);
    we0 = 1'b1; wd0 = d; @(posedge clk); #1; we0 = 1'b0;
  endtask
  task automatic wr1(input logic [31:0] d);
    we1 = 1'b1; wd1 = d; @(posedge clk); #1; we1 = 1'b0;
  endtask
  task automatic drain0(input int lim);
    int n = 0;
    while (sb0.size() != 0 && n < lim) begin @(negedge clk); #1; n++; end
    if (sb0.size() != 0) chk("drain0_timeout", sb0.size(), 64'd0);
  endtask
  task automatic drain1(input int lim);
    int n = 0;
    while (sb1.size() != 0 && n < lim) begin @(negedge clk); #1; n++; end
    if (sb1.size() != 0) chk("drain1_timeout", sb1.size(), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    rst_n = 1'b0; rst1_n = 1'b0; we0 = 1'b0; we1 = 1'b0; wd0 = '0; wd1 = '0;
    rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: idle after reset with an empty FIFO
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_valid", vld0, 0); chk("t1_read", rd0, 0);
      chk("t1_busy", busy0, 0); chk("t1_last", last0, 0);
    end
    @(posedge clk); #1;

    // T2: one word, latency and slice order
    rdy0 = 1'b1; beats0 = 0;
    wr0(32'h44332211);
    @(negedge clk); chk("t2_read_issue", rd0, 1); chk("t2_valid_c0", vld0, 0);
    @(negedge clk); chk("t2_valid_c1", vld0, 0); chk("t2_busy_inflight", busy0, 1);
    @(negedge clk); chk("t2_valid_c2", vld0, 1); chk("t2_first_beat", dat0, 8'h11);
    #1; drain0(20);
    chk("t2_beats", beats0, 4); chk("t2_span", t_last0 - t_first0, 3);
    @(negedge clk); chk("t2_idle_valid", vld0, 0); chk("t2_idle_busy", busy0, 0);
    @(posedge clk); #1;

    // T3: 8 words back-to-back
    beats0 = 0; rdcnt0 = 0;
    for (int i = 0; i < 8; i++) wr0(i);
    drain0(80);
    chk("t3_beats", beats0, 32); chk("t3_span", t_last0 - t_first0, 31);
    repeat (2) @(negedge clk);
    chk("t3_reads", rdcnt0, 8); chk("t3_idle_valid", vld0, 0);
    @(posedge clk); #1;

    // T4: backpressure with ready toggling
    rdy0 = 1'b0; beats0 = 0; rdcnt0 = 0; pop_seen = 1'b0; stalls0 = 0;
    for (int i = 0; i < 3; i++) wr0($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_prefetch_stopped", rd0, 0); chk("t4_fifo_holds_one", emp0, 0);
    chk("t4_valid_held", vld0, 1); chk("t4_reads_prefetched", rdcnt0, 2);
    @(posedge clk); #1;
    n = 0;
    while (sb0.size() != 0 && n < 100) begin rdy0 = ~rdy0; @(posedge clk); #1; n++; end
    chk("t4_drained", sb0.size(), 0);
    chk("t4_beats", beats0, 12); chk("t4_reads_before_pop", rd_at_pop, 2);
    chk("t4_stalls_seen", stalls0 >= 4, 1);
    rdy0 = 1'b1;

    // T5: Ratio=1, 9 writes into a depth-8 FIFO while the unpacker is held in reset
    rdy1 = 1'b1; beats1 = 0;
    for (int i = 0; i < 9; i++) wr1($urandom);
    @(negedge clk); chk("t5_read_in_reset", rd1, 0); chk("t5_valid_in_reset", vld1, 0);
    @(posedge clk); #1 rst1_n = 1'b1;
    drain1(40);
    chk("t5_beats", beats1, 8); chk("t5_span", t_last1 - t_first1, 7);
    repeat (3) @(negedge clk);
    chk("t5_idle_valid", vld1, 0); chk("t5_idle_busy", busy1, 0);
    @(posedge clk); #1;

    // T6: reset asserted mid-word at beat 2
    beats0 = 0;
    wr0(32'hDDCCBBAA);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (vld0 && dat0 == 8'hCC) found = 1'b1;
    end
    chk("t6_reached_beat2", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_async", vld0, 0); chk("t6_read_async", rd0, 0);
    chk("t6_busy_async", busy0, 0); chk("t6_last_async", last0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; beats0 = 0;
    @(negedge clk); chk("t6_no_stale", vld0, 0);
    @(posedge clk); #1;
    wr0(32'h88776655);
    drain0(20);
    chk("t6_beats", beats0, 4); chk("t6_span", t_last0 - t_first0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
